// File: rtl/stream_packer.sv
// stream_packer: packs NUM_WORDS consecutive DATA_W input beats into one wide vector.
//   The vector is emitted on a valid/ready output with full throughput.
//   Ports:
//     clk       - clock, rising edge
//     rst       - asynchronous active-low reset
//     in_data   - input beat
//     in_valid  - input beat valid
//     in_ready  - packer can accept a beat
//     in_last   - last beat of a vector (PACK_LAST_CHK_EN only)
//     err       - sticky framing error (PACK_LAST_CHK_EN only)
//     out_data  - packed vector; beat k occupies bits [k*DATA_W +: DATA_W]
//     out_valid - vector valid
//     out_ready - downstream accepts vector
//   Optional feature macro: PACK_LAST_CHK_EN (in_last framing check and err flag).
module stream_packer #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
`ifdef PACK_LAST_CHK_EN
    input  logic                        in_last,
    output logic                        err,
`endif
    output logic [DATA_W*NUM_WORDS-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
    typedef enum logic {FILL, HOLD} state_t;
    state_t state;
    logic [IW-1:0] idx;
    logic in_fire, out_fire, at_last, close;
    logic [DATA_W*NUM_WORDS-1:0] nxt_data;
    // In HOLD a beat may only enter when the held vector leaves in the same cycle.
    assign in_ready = rst && (state == FILL || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign at_last  = idx == LAST;
`ifdef PACK_LAST_CHK_EN
    assign close = at_last || in_last;
`else
    assign close = at_last;
`endif
    // Slot idx takes the beat; an early last clears the slots it never reached.
    always_comb begin
        nxt_data = out_data;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (k == int'(idx))
                nxt_data[k*DATA_W +: DATA_W] = in_data;
`ifdef PACK_LAST_CHK_EN
            else if (in_last && k > int'(idx))
                nxt_data[k*DATA_W +: DATA_W] = '0;
`endif
        end
    end
    // A beat accepted in the same cycle as the output handshake overrides the
    // return to FILL only when it closes a vector by itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_fire) begin
                state     <= FILL;
                out_valid <= 1'b0;
            end
            if (in_fire) begin
                out_data <= nxt_data;
                idx      <= close ? '0 : idx + 1'b1;
                if (close) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
            end
        end
    end
`ifdef PACK_LAST_CHK_EN
    // Early last and missing last are both a mismatch between in_last and the slot count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (in_fire && (in_last != at_last))
            err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed table-driven bench for stream_packer (DATA_W=8, NUM_WORDS=4).
module tb_stream_packer;
    localparam int DW = 8;
    localparam int NW = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [DW*NW-1:0] out_data;
    logic out_valid;
    logic out_ready = 1'b0;
`ifdef PACK_LAST_CHK_EN
    logic in_last = 1'b0;
    logic err;
`endif
    int n_chk = 0;
    int n_fail = 0;

    stream_packer #(.DATA_W(DW), .NUM_WORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef PACK_LAST_CHK_EN
        .in_last   (in_last),
        .err       (err),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od);
        vec_t r;
        r.v = v; r.d = d; r.ordy = ordy; r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od;
        tbl.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data = d;
        step();
    endtask

    initial begin
        // back-to-back vectors, no bubble at the boundary
        add(1, 8'h11, 1, 1, 0, 32'h00000000);
        add(1, 8'h22, 1, 1, 0, 32'h00000011);
        add(1, 8'h33, 1, 1, 0, 32'h00002211);
        add(1, 8'h44, 1, 1, 0, 32'h00332211);
        add(1, 8'h55, 1, 1, 1, 32'h44332211);
        add(1, 8'h66, 1, 1, 0, 32'h44332255);
        add(1, 8'h77, 1, 1, 0, 32'h44336655);
        add(1, 8'h88, 1, 1, 0, 32'h44776655);
        add(0, 8'hEE, 1, 1, 1, 32'h88776655);
        add(0, 8'hEE, 1, 1, 0, 32'h88776655);
        // backpressure for 5 cycles with 0x55 waiting
        add(1, 8'h11, 1, 1, 0, 32'h88776655);
        add(1, 8'h22, 1, 1, 0, 32'h88776611);
        add(1, 8'h33, 1, 1, 0, 32'h88772211);
        add(1, 8'h44, 0, 1, 0, 32'h88332211);
        for (int i = 0; i < 5; i++) add(1, 8'h55, 0, 0, 1, 32'h44332211);
        add(1, 8'h55, 1, 1, 1, 32'h44332211);
        add(0, 8'hEE, 1, 1, 0, 32'h44332255);
        add(1, 8'h66, 1, 1, 0, 32'h44332255);
        add(1, 8'h77, 1, 1, 0, 32'h44336655);
        add(1, 8'h88, 1, 1, 0, 32'h44776655);
        add(0, 8'hEE, 1, 1, 1, 32'h88776655);
        add(0, 8'hEE, 1, 1, 0, 32'h88776655);
        // bubbles of 1,3,0 idle cycles between beats
        add(1, 8'hA1, 1, 1, 0, 32'h88776655);
        add(0, 8'hEE, 1, 1, 0, 32'h887766A1);
        add(1, 8'hB2, 1, 1, 0, 32'h887766A1);
        add(0, 8'hEE, 1, 1, 0, 32'h8877B2A1);
        add(0, 8'hEE, 1, 1, 0, 32'h8877B2A1);
        add(0, 8'hEE, 1, 1, 0, 32'h8877B2A1);
        add(1, 8'hC3, 1, 1, 0, 32'h8877B2A1);
        add(1, 8'hD4, 1, 1, 0, 32'h88C3B2A1);
        add(0, 8'hEE, 0, 0, 1, 32'hD4C3B2A1);
        add(0, 8'hEE, 1, 1, 1, 32'hD4C3B2A1);
        add(0, 8'hEE, 1, 1, 0, 32'hD4C3B2A1);

        // reset held with in_valid asserted
        in_valid = 1'b1;
        in_data = 8'h5A;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst in_ready", in_ready, 0);
            chk("rst out_valid", out_valid, 0);
            chk("rst out_data", out_data, 0);
        end
        rst = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1);
        chk("release out_valid", out_valid, 0);
        in_valid = 1'b0;
        step();
        chk("release out_data", out_data, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v;
            in_data = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
            step();
        end

        // asynchronous reset pulse mid-fill discards the partial vector
        out_ready = 1'b1;
        beat(8'h11);
        beat(8'h22);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_data", out_data, 0);
        #1;
        rst = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("midfill%0d out_valid", b), out_valid, 0);
            beat(8'(b));
        end
        in_valid = 1'b0;
        #1;
        chk("midfill vec out_valid", out_valid, 1);
        chk("midfill vec out_data", out_data, 32'h04030201);
        step();
        chk("midfill consumed", out_valid, 0);

`ifdef PACK_LAST_CHK_EN
        rst = 1'b0;
        #1;
        rst = 1'b1;
        chk("err after reset", err, 0);
        beat(8'h11);
        beat(8'h22);
        in_last = 1'b1;
        beat(8'h33);
        in_last = 1'b0;
        in_valid = 1'b0;
        chk("early last out_valid", out_valid, 1);
        chk("early last out_data", out_data, 32'h00332211);
        chk("early last err", err, 1);
        beat(8'h41);
        beat(8'h42);
        beat(8'h43);
        in_last = 1'b1;
        beat(8'h44);
        in_last = 1'b0;
        in_valid = 1'b0;
        chk("good vec out_data", out_data, 32'h44434241);
        chk("err sticky", err, 1);
        rst = 1'b0;
        #1;
        chk("err cleared", err, 0);
        rst = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Receiving end of the valid/ready word stream produced by the master-side handshake block.
- Accepts narrow DATA_W beats and packs NUM_WORDS consecutive beats into one wide vector.
- Presents the vector on a second valid/ready interface that feeds the neuron datapath.
- Full throughput: one beat per cycle, with no bubble at vector boundaries.

Parameters:
- DATA_W, 8, width of one input beat.
- NUM_WORDS, 4, beats per output vector, >=1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  beat from upstream master.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  packer can accept a beat.
- out_data  output  DATA_W*NUM_WORDS  packed vector; beat k occupies bits [k*DATA_W +: DATA_W], so beat 0 sits at the LSBs.
- out_valid  output  1  vector valid.
- out_ready  input  1  downstream accepts vector.

Behaviour:
- Handshakes:
  - Input beat transfers when in_valid & in_ready on a rising edge.
  - Output vector transfers when out_valid & out_ready on a rising edge.
- Reset (rst low, asynchronous):
  - state=FILL, idx=0, out_data=0, out_valid=0.
  - in_ready forced 0 while rst is low.
  - Any partial vector is discarded.
  - Normal operation starts on the first edge after rst rises; in_ready=1 from that point.
- Index register idx: width clog2(NUM_WORDS), min 1 bit. Counts 0..NUM_WORDS-1 and wraps to 0 after the last beat.
- State FILL:
  - in_ready=1, out_valid=0.
  - On input handshake: out_data slot idx <= in_data.
  - If idx<NUM_WORDS-1: idx++.
  - If idx==NUM_WORDS-1: idx<=0, state<=HOLD, out_valid<=1.
- State HOLD:
  - out_valid=1; out_data is stable until the output handshake.
  - in_ready = out_ready. This combinational path is intentional and gives zero-bubble turnover.
  - Output handshake without an input beat: state<=FILL, out_valid<=0.
  - Output handshake with an input beat in the same cycle: the beat is written to slot 0 and idx<=1, state<=FILL.
    - If NUM_WORDS==1, it instead stays in HOLD with the new vector.
  - out_ready=0: no state change; in_valid/in_data are ignored (in_ready=0).
- Latency: out_valid rises the cycle after the handshake of the final beat.
- Slots of a new vector are overwritten in place. No zero-clearing between vectors, except as described under the optional feature.
- in_data is a don't-care when in_valid=0; idx does not advance.
- Upstream may deassert in_valid at any cycle (bubbles); packing order is unaffected.

Optional Feature:
- Macro: PACK_LAST_CHK_EN.
- Defined:
  - Adds input in_last (1 bit) and output err (1 bit, reset 0, sticky until reset).
  - in_last is sampled on input handshake.
  - Early last (in_last=1 with idx<NUM_WORDS-1):
    - The vector closes immediately: state<=HOLD, out_valid<=1, idx<=0.
    - Unfilled slots (idx+1..NUM_WORDS-1) are written 0.
    - err<=1.
  - Missing last (in_last=0 on beat NUM_WORDS-1): the vector is emitted normally and err<=1.
- Undefined: in_last and err ports do not exist; grouping is purely by count.

Test Plan:
- Reset release: hold rst=0 with in_valid=1, then release -> in_ready=0 during reset; out_valid=0 and out_data=0 throughout; in_ready=1 the first cycle after release.
- Back-to-back beats, DATA_W=8, NUM_WORDS=4: beats 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> out_data=0x44332211, out_valid for exactly one cycle, one cycle after the 0x44 handshake. Continuing with 0x55..0x88 -> 0x88776655 follows with no bubble.
- Backpressure: vector 0x44332211 held with out_ready=0 for 5 cycles; 0x55 presented and stable -> in_ready=0 and out_data unchanged all 5 cycles. Raising out_ready -> vector consumed and 0x55 accepted in the same cycle; next vector's slot 0 = 0x55.
- Bubbles: beats 0xA1,0xB2,0xC3,0xD4 interleaved with 0-3 idle cycles of in_valid=0 -> out_data=0xD4C3B2A1; no early or extra out_valid.
- Reset mid-fill: after 0x11,0x22 accepted, pulse rst low asynchronously (between edges) -> out_valid stays 0. Subsequent beats 0x01..0x04 -> out_data=0x04030201.
- With PACK_LAST_CHK_EN: beats 0x11,0x22,0x33 with in_last=1 on 0x33 -> out_data=0x00332211, err=1 and stays 1 across the next correctly terminated vector until reset.
